// File: rtl/si_matrix_max7219_driver.sv
// si_matrix_max7219_driver: serialises eight 8-bit rows into a MAX7219 over DIN/SCLK/CS.
// Define SI_MATRIXDRV_SKIP_UNCHANGED_EN to skip rows equal to the value last sent.
module si_matrix_max7219_driver #(
    parameter int CLK_DIV   = 4,
    parameter int INTENSITY = 8
) (
    input  logic       SI_MATRIXDRV_CLOCK_50,
    input  logic       SI_MATRIXDRV_RESET,
    input  logic       SI_MATRIXDRV_ENABLE_In,
    input  logic [7:0] SI_MATRIXDRV_FILA0_InBUS,
    input  logic [7:0] SI_MATRIXDRV_FILA1_InBUS,
    input  logic [7:0] SI_MATRIXDRV_FILA2_InBUS,
    input  logic [7:0] SI_MATRIXDRV_FILA3_InBUS,
    input  logic [7:0] SI_MATRIXDRV_FILA4_InBUS,
    input  logic [7:0] SI_MATRIXDRV_FILA5_InBUS,
    input  logic [7:0] SI_MATRIXDRV_FILA6_InBUS,
    input  logic [7:0] SI_MATRIXDRV_FILA7_InBUS,
    output logic       SI_MATRIXDRV_DIN_Out,
    output logic       SI_MATRIXDRV_SCLK_Out,
    output logic       SI_MATRIXDRV_CS_Out,
    output logic       SI_MATRIXDRV_INITDONE_Out,
    output logic       SI_MATRIXDRV_FRAMEDONE_Out,
    output logic       SI_MATRIXDRV_BUSY_Out
);
    typedef enum logic [1:0] {INIT, IDLE, SEND_ROWS} state_t;
    state_t      state;
    logic [7:0]  tcnt;
    logic [5:0]  phase;
    logic [2:0]  init_idx;
    logic [7:0]  pend;
    logic [7:0]  pend_next;
    logic [7:0]  cap_mask;
    logic [7:0]  snap [8];
    logic [7:0]  fila [8];
    logic [2:0]  row;
    logic [3:0]  addr;
    logic [15:0] init_word;
    logic [15:0] word;
    logic        tick;

    assign tick = tcnt == 8'(CLK_DIV - 1);
    always_comb begin
        fila = '{SI_MATRIXDRV_FILA0_InBUS, SI_MATRIXDRV_FILA1_InBUS, SI_MATRIXDRV_FILA2_InBUS,
                 SI_MATRIXDRV_FILA3_InBUS, SI_MATRIXDRV_FILA4_InBUS, SI_MATRIXDRV_FILA5_InBUS,
                 SI_MATRIXDRV_FILA6_InBUS, SI_MATRIXDRV_FILA7_InBUS};
    end
    // Rows still owed in this frame; the lowest pending one is the word in flight.
    always_comb begin
        row = '0;
        for (int i = 7; i >= 0; i--) if (pend[i]) row = 3'(i);
    end
    assign pend_next = pend & ~(8'd1 << row);
    assign addr = {1'b0, row} + 4'd1;
    assign init_word = init_idx == 3'd0 ? 16'h0C01 :
                       init_idx == 3'd1 ? 16'h0900 :
                       init_idx == 3'd2 ? 16'h0B07 :
                       init_idx == 3'd3 ? {12'h0A0, 4'(INTENSITY)} : 16'h0F00;
    assign word = state == INIT ? init_word : {4'h0, addr, snap[row]};

`ifdef SI_MATRIXDRV_SKIP_UNCHANGED_EN
    logic [7:0] last [8];
    always_ff @(posedge SI_MATRIXDRV_CLOCK_50) begin
        if (SI_MATRIXDRV_RESET) last <= '{default: '0};
        else if (state == SEND_ROWS && pend != '0 && tick && phase == 6'd32) last[row] <= snap[row];
    end
    always_comb begin
        cap_mask = '0;
        for (int i = 0; i < 8; i++) cap_mask[i] = fila[i] != last[i];
    end
`else
    assign cap_mask = 8'hFF;
`endif

    always_ff @(posedge SI_MATRIXDRV_CLOCK_50) begin
        if (SI_MATRIXDRV_RESET) begin
            state                      <= INIT;
            tcnt                       <= '0;
            phase                      <= '0;
            init_idx                   <= '0;
            pend                       <= '0;
            SI_MATRIXDRV_SCLK_Out      <= 1'b0;
            SI_MATRIXDRV_CS_Out        <= 1'b1;
            SI_MATRIXDRV_DIN_Out       <= 1'b0;
            SI_MATRIXDRV_INITDONE_Out  <= 1'b0;
            SI_MATRIXDRV_FRAMEDONE_Out <= 1'b0;
            SI_MATRIXDRV_BUSY_Out      <= 1'b0;
        end else begin
            tcnt <= tick ? '0 : tcnt + 8'd1;
            SI_MATRIXDRV_FRAMEDONE_Out <= 1'b0;
            if (state == IDLE) begin
                if (SI_MATRIXDRV_ENABLE_In) begin
                    snap  <= fila;
                    pend  <= cap_mask;
                    state <= SEND_ROWS;
                end
            end else if (state == SEND_ROWS && pend == '0) begin
                SI_MATRIXDRV_FRAMEDONE_Out <= 1'b1;
                state <= IDLE;
            end else if (tick) begin
                phase <= phase == 6'd33 ? '0 : phase + 6'd1;
                if (phase == 6'd0) begin
                    SI_MATRIXDRV_CS_Out   <= 1'b0;
                    SI_MATRIXDRV_SCLK_Out <= 1'b0;
                    SI_MATRIXDRV_DIN_Out  <= word[15];
                    SI_MATRIXDRV_BUSY_Out <= 1'b1;
                end else if (phase == 6'd32) begin
                    SI_MATRIXDRV_SCLK_Out <= 1'b0;
                    SI_MATRIXDRV_CS_Out   <= 1'b1;
                end else if (phase == 6'd33) begin
                    SI_MATRIXDRV_BUSY_Out <= 1'b0;
                    if (state == INIT) begin
                        init_idx <= init_idx + 3'd1;
                        if (init_idx == 3'd4) begin
                            SI_MATRIXDRV_INITDONE_Out <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        pend <= pend_next;
                        if (pend_next == '0) begin
                            SI_MATRIXDRV_FRAMEDONE_Out <= 1'b1;
                            state <= IDLE;
                        end else if (!SI_MATRIXDRV_ENABLE_In) begin
                            state <= IDLE;
                        end
                    end
                end else if (phase[0]) begin
                    SI_MATRIXDRV_SCLK_Out <= 1'b1;
                end else begin
                    SI_MATRIXDRV_SCLK_Out <= 1'b0;
                    SI_MATRIXDRV_DIN_Out  <= word[4'd15 - phase[4:1]];
                end
            end
        end
    end
endmodule

// File: doc/si_matrix_max7219_driver.md
Name: si_matrix_max7219_driver

Overview:
- Downstream consumer of the ship/bullet subsystem's eight 8-bit row buses (FILA0..FILA7).
- Serialises those rows into a MAX7219 8x8 LED matrix controller over a 3-wire serial link (DIN/SCLK/CS).
- On reset it programs the controller's configuration registers once, then refreshes all eight digit registers continuously.
- All eight rows are snapshotted at the start of each refresh frame, so a frame never mixes game states.

Parameters:
- CLK_DIV, 4: system clocks per tick; one SCLK half-period is one tick. Legal range is 1..255.
- INTENSITY, 8: 4-bit value written to the intensity register (0x0A).

Ports:
- SI_MATRIXDRV_CLOCK_50  in  1  system clock, 50 MHz.
- SI_MATRIXDRV_RESET  in  1  reset, synchronous, active-high.
- SI_MATRIXDRV_ENABLE_In  in  1  refresh enable, active-high.
- SI_MATRIXDRV_FILA0_InBUS..SI_MATRIXDRV_FILA7_InBUS  in  8 each  row data; FILAk drives digit register k+1.
- SI_MATRIXDRV_DIN_Out  out  1  serial data, MSB first.
- SI_MATRIXDRV_SCLK_Out  out  1  serial clock, idles low.
- SI_MATRIXDRV_CS_Out  out  1  chip select/load, active-low; data is latched by the controller on the rising edge.
- SI_MATRIXDRV_INITDONE_Out  out  1  high once the init sequence has completed.
- SI_MATRIXDRV_FRAMEDONE_Out  out  1  one-cycle pulse after the 8th row word of a frame.
- SI_MATRIXDRV_BUSY_Out  out  1  high while a word is in flight.

Behaviour:
- Reset values: SCLK=0, CS=1, DIN=0, INITDONE=0, FRAMEDONE=0, BUSY=0. Tick counter, bit counter, word index and state are all cleared.
- Reset asserted mid-word aborts the word immediately: CS=1 on the next edge, and the init sequence re-runs after release.
- Tick generator: a free-running counter 0..CLK_DIV-1 produces a one-cycle tick at CLK_DIV-1. All output changes occur on tick cycles only.
- Word format is 16 bits: {4'b0000, addr[3:0], data[7:0]}, sent MSB first.
- Word timing, 34 ticks per word:
  - T0: CS=0, SCLK=0, DIN=bit15.
  - T(2i+1): SCLK=1.
  - T(2i+2): SCLK=0, DIN=bit(14-i).
  - After the 32nd half-period: SCLK=0, CS=1 (latch).
  - One gap tick with CS=1.
  - Total is 34*CLK_DIV system clocks.
- BUSY is high from T0 through the latch tick.
- FSM states and transitions:
  - INIT: sends 5 words in fixed order:
    - 0x0C01 (shutdown off)
    - 0x0900 (no decode)
    - 0x0B07 (scan limit 7)
    - 0x0A0{INTENSITY}
    - 0x0F00 (display test off)
  - INIT proceeds regardless of ENABLE. At the end of INIT's last gap tick, INITDONE=1 and stays high until reset.
  - IDLE: if ENABLE=1, capture all 8 FILA inputs into the snapshot register in that cycle and go to SEND_ROWS. Otherwise remain in IDLE with CS=1 and SCLK=0.
  - SEND_ROWS: for word index k=0..7, send {4'h0, k+1, snap[k]}. After the gap tick of k=7, pulse FRAMEDONE for one cycle and go to IDLE.
  - Back-to-back refresh: IDLE with ENABLE=1 recaptures on the next cycle.
- ENABLE deasserted mid-frame: the current word completes (latch and gap), then the FSM goes to IDLE. The partial frame gets no FRAMEDONE. Re-enabling starts a fresh frame at digit 1; init is not repeated.
- FILA inputs changing during a frame have no effect until the next snapshot.
- The tick counter keeps running in IDLE, so T0 of a new word lands on the next tick boundary. Latency from the capture cycle to CS falling is at most CLK_DIV cycles.

Optional Feature:
- Macro: SI_MATRIXDRV_SKIP_UNCHANGED_EN.
- Defined:
  - An 8x8 "last sent" register holds the last row data transmitted per digit. It is cleared to 0 by reset, which forces a full first frame.
  - In SEND_ROWS, a row whose snapshot equals its last-sent value is skipped with zero ticks consumed.
  - A frame with no changed rows still pulses FRAMEDONE, one cycle after capture.
  - The last-sent entry is updated at the latch tick.
- Undefined: every frame sends all 8 rows, and the last-sent register is not present.

Test Plan:
- Reset then release, ENABLE=0, CLK_DIV=2 -> exactly 5 CS low pulses with words 0x0C01, 0x0900, 0x0B07, 0x0A08, 0x0F00. INITDONE rises at cycle 340 after release, and there is no further CS activity.
- ENABLE=1, FILA0=0x18, FILA7=0x81, others 0x00, CLK_DIV=2 -> 8 words 0x0118, 0x0200 .. 0x0700, 0x0881. FRAMEDONE pulses once, 544 cycles after capture.
- FILA3 changed 0x00->0xFF during the 2nd word of a frame -> the current frame sends 0x0400. The next frame sends 0x04FF.
- ENABLE dropped during word k=2 -> word 0x03xx completes with CS high and 16 SCLK rising edges. No FRAMEDONE. Re-enable -> next word is 0x01xx.
- Reset asserted at bit 7 of a row word -> CS=1 and SCLK=0 next cycle. After release the init words are resent starting at 0x0C01.
- With SKIP_UNCHANGED_EN, two frames of identical data -> frame 1 sends 8 words. Frame 2 sends 0 words, with FRAMEDONE one cycle after capture.
